// File: rtl/mac_sequencer.sv
// Job sequencer for the 8x8 unsigned multiplier: streams operand pairs through a
// two-stage multiply pipeline and returns the accumulated dot product.
module mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] len_q, count;
  logic [7:0]       a_q, b_q;
  logic             v1, v2;
  logic [15:0]      p_q, prod;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic             accept, last_accept, job_start;
  logic [ACC_W:0]   acc_sum;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (count == len_q - LEN_W'(1));
  assign job_start   = (state == IDLE) && start;
  assign acc_sum     = {1'b0, acc} + {{(ACC_W-15){1'b0}}, p_q};

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (last_accept) state_next = DRAIN;
      end
      // Once v1 is empty, the product in stage 2 is accumulated on this same edge.
      DRAIN: if (!v1) state_next = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      count <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (job_start) begin
        len_q <= len;
        count <= '0;
        acc   <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (accept) count <= count + LEN_W'(1);
        if (v2) begin
          acc <= acc_sum[ACC_W-1:0];
          if (acc_sum[ACC_W]) ovf_q <= 1'b1;
        end
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; their valid bits (v1/v2) are what get cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
    p_q <= prod;
  end

  // Dadda multiplier: partial-product rows reduced with 3:2 compressors through
  // heights 8-6-4-3-2, then one carry-propagate add.
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [15:0] pp [8];
  logic [15:0] s1a, c1a, s1b, c1b, s2a, c2a, s2b, c2b, s3, c3, s4, c4;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'd0, a_q & {8{b_q[i]}}} << i;
    end
  end

  assign {c1a, s1a} = csa(pp[0], pp[1], pp[2]);
  assign {c1b, s1b} = csa(pp[3], pp[4], pp[5]);
  assign {c2a, s2a} = csa(s1a, c1a, s1b);
  assign {c2b, s2b} = csa(c1b, pp[6], pp[7]);
  assign {c3, s3}   = csa(s2a, c2a, s2b);
  assign {c4, s4}   = csa(s3, c3, c2b);
  assign prod       = s4 + c4;

  assign result = acc;
  assign ovf    = ovf_q;

endmodule
